// File: rtl/ring_counter_monitor.sv
// rtl/ring_counter_monitor.sv - one-hot ring sequence monitor with lock, index decode and error count
// Optional build macro: RING_MON_FLYWHEEL_EN (LOCKED tolerates one isolated bad sample)
module ring_counter_monitor #(
    parameter  int WIDTH    = 4,
    parameter  int LOCK_CNT = 3,
    parameter  int ERR_W    = 8,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ring_in,
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             locked,
    output logic             onehot_err,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             index_valid_q, index_valid_d;
    logic             onehot_err_q, onehot_err_d;
    logic             seq_err_q, seq_err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
`ifdef RING_MON_FLYWHEEL_EN
    logic             miss_q, miss_d;
`endif

    logic             oh;
    logic             ok;
    logic [WIDTH-1:0] exp_phase;
    logic [3:0]       cnt_inc;
    logic [ERR_W-1:0] err_inc;

    function automatic logic [IDX_W-1:0] decode(input logic [WIDTH-1:0] v);
        decode = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (v[k]) decode = IDX_W'(k);
        end
    endfunction

    always_comb begin
        oh        = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
        exp_phase = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
        ok        = oh && (ring_in == exp_phase);
        cnt_inc   = match_cnt_q + 4'd1;
        err_inc   = (err_count_q == '1) ? err_count_q : err_count_q + ERR_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        match_cnt_d   = match_cnt_q;
        index_d       = index_q;
        index_valid_d = index_valid_q;
        onehot_err_d  = 1'b0;
        seq_err_d     = 1'b0;
        err_count_d   = err_count_q;
`ifdef RING_MON_FLYWHEEL_EN
        miss_d        = miss_q;
`endif
        if (in_valid) begin
            onehot_err_d = !oh;
            case (state_q)
                HUNT: begin
                    if (oh) begin
                        prev_d      = ring_in;
                        match_cnt_d = '0;
                        state_d     = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (ok) begin
                        match_cnt_d = cnt_inc;
                        prev_d      = ring_in;
                        if (cnt_inc == 4'(LOCK_CNT)) begin
                            state_d       = LOCKED;
                            index_d       = decode(ring_in);
                            index_valid_d = 1'b1;
                        end
                    end else if (oh) begin
                        prev_d      = ring_in;
                        match_cnt_d = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (ok) begin
                        prev_d        = ring_in;
                        index_d       = decode(ring_in);
                        index_valid_d = 1'b1;
`ifdef RING_MON_FLYWHEEL_EN
                        miss_d        = 1'b0;
                    end else if (!miss_q) begin
                        // Coast on the predicted phase for one sample
                        miss_d  = 1'b1;
                        prev_d  = exp_phase;
                        index_d = decode(exp_phase);
`endif
                    end else begin
                        seq_err_d     = 1'b1;
                        err_count_d   = err_inc;
                        state_d       = HUNT;
                        index_valid_d = 1'b0;
`ifdef RING_MON_FLYWHEEL_EN
                        miss_d        = 1'b0;
`endif
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= HUNT;
            prev_q        <= '0;
            match_cnt_q   <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            onehot_err_q  <= 1'b0;
            seq_err_q     <= 1'b0;
            err_count_q   <= '0;
`ifdef RING_MON_FLYWHEEL_EN
            miss_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            match_cnt_q   <= match_cnt_d;
            index_q       <= index_d;
            index_valid_q <= index_valid_d;
            onehot_err_q  <= onehot_err_d;
            seq_err_q     <= seq_err_d;
            err_count_q   <= err_count_d;
`ifdef RING_MON_FLYWHEEL_EN
            miss_q        <= miss_d;
`endif
        end
    end

    assign index       = index_q;
    assign index_valid = index_valid_q;
    assign locked      = (state_q == LOCKED);
    assign onehot_err  = onehot_err_q;
    assign seq_err     = seq_err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_ring_counter_monitor.sv
// tb/tb_ring_counter_monitor.sv - randomized self-checking bench for ring_counter_monitor
module tb_ring_counter_monitor;

    localparam int W     = 4;
    localparam int LOCKN = 3;
    localparam int EW    = 8;
`ifdef RING_MON_FLYWHEEL_EN
    localparam bit FLY = 1'b1;
`else
    localparam bit FLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  ring_in = '0;
    logic [1:0]    index;
    logic          index_valid;
    logic          locked;
    logic          onehot_err;
    logic          seq_err;
    logic [EW-1:0] err_count;

    int checks = 0;
    int errors = 0;

    // Reference model: phases held as integer positions, states as small ints
    int m_state;        // 0 hunt, 1 confirm, 2 locked
    int m_prev;
    int m_cnt;
    int m_index;
    int m_iv;
    int m_err;
    int m_miss;
    int m_oh_err;
    int m_seq_err;

    ring_counter_monitor #(.WIDTH(W), .LOCK_CNT(LOCKN), .ERR_W(EW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .ring_in(ring_in),
        .index(index), .index_valid(index_valid), .locked(locked),
        .onehot_err(onehot_err), .seq_err(seq_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_cnt = 0; m_index = 0; m_iv = 0;
        m_err = 0; m_miss = 0; m_oh_err = 0; m_seq_err = 0;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".locked"},      int'(locked),      int'(m_state == 2));
        check({ctx, ".index_valid"}, int'(index_valid), m_iv);
        check({ctx, ".index"},       int'(index),       m_index);
        check({ctx, ".onehot_err"},  int'(onehot_err),  m_oh_err);
        check({ctx, ".seq_err"},     int'(seq_err),     m_seq_err);
        check({ctx, ".err_count"},   int'(err_count),   m_err);
    endtask

    task automatic model_step(input bit v, input logic [W-1:0] r);
        bit is_oh;
        int pos;
        bit good;
        m_oh_err  = 0;
        m_seq_err = 0;
        if (!v) return;
        is_oh = ($countones(r) == 1);
        pos = 0;
        for (int k = 0; k < W; k++) if (r[k]) pos = k;
        good = is_oh && (pos == (m_prev + 1) % W);
        m_oh_err = !is_oh;
        case (m_state)
            0: if (is_oh) begin m_prev = pos; m_cnt = 0; m_state = 1; end
            1: begin
                if (good) begin
                    m_cnt++;
                    m_prev = pos;
                    if (m_cnt == LOCKN) begin m_state = 2; m_index = pos; m_iv = 1; end
                end else if (is_oh) begin
                    m_prev = pos; m_cnt = 0;
                end else begin
                    m_state = 0;
                end
            end
            default: begin
                if (good) begin
                    m_prev = pos; m_index = pos; m_iv = 1; m_miss = 0;
                end else if (FLY && m_miss == 0) begin
                    m_miss = 1;
                    m_prev = (m_prev + 1) % W;
                    m_index = m_prev;
                end else begin
                    m_seq_err = 1;
                    if (m_err < (1 << EW) - 1) m_err++;
                    m_state = 0; m_iv = 0; m_miss = 0;
                end
            end
        endcase
    endtask

    // Called just after a falling edge; samples results on the next falling edge
    task automatic step(input bit v, input logic [W-1:0] r, input string ctx);
        in_valid = v;
        ring_in  = r;
        @(posedge clk);
        model_step(v, r);
        @(negedge clk);
        check_all(ctx);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all("reset_async");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int r;
        int src;
        logic [W-1:0] val;

        model_reset();
        @(negedge clk);
        check_all("reset_state");
        reset = 1'b1;

        // Acquire lock and follow the wrap
        step(1, 4'b0001, "t1a");
        step(1, 4'b0010, "t1b");
        step(1, 4'b0100, "t1c");
        step(1, 4'b1000, "t1d");
        check("t1.locked_const", int'(locked), 1);
        check("t1.index_const", int'(index), 3);
        step(1, 4'b0001, "t2a");
        check("t2.wrap_index", int'(index), 0);
        step(1, 4'b0010, "t2b");
        step(0, 4'b1111, "idle_hold");
        // Out-of-sequence sample while locked
        step(1, 4'b1000, "t3a");
        if (FLY) step(1, 4'b0001, "t6b_loss");
        else check("t3.seq_err_const", int'(seq_err), 1);
        check("t3.err_count_const", int'(err_count), 1);
        step(1, 4'b0110, "t4a");
        step(1, 4'b0000, "t4b");

        // Mid-operation asynchronous reset
        step(1, 4'b0001, "pre_rst_a");
        step(1, 4'b0010, "pre_rst_b");
        @(posedge clk);
        #2;
        do_reset();

        // Flywheel scenarios (model covers both builds)
        step(1, 4'b0001, "f_a"); step(1, 4'b0010, "f_b");
        step(1, 4'b0100, "f_c"); step(1, 4'b1000, "f_d");
        step(1, 4'b0001, "f_e"); step(1, 4'b0010, "f_f");
        step(1, 4'b1000, "f_g");
        step(1, 4'b1000, "f_h");
        if (FLY) check("t6.keep_lock", int'(locked), 1);
        step(1, 4'b0001, "f_i"); step(1, 4'b0010, "f_j");
        step(1, 4'b1000, "f_k");
        step(1, 4'b0001, "f_l");

        // Saturation of err_count
        do_reset();
        for (int i = 0; i < 257; i++) begin
            step(1, 4'b0001, "sat_a"); step(1, 4'b0010, "sat_b");
            step(1, 4'b0100, "sat_c"); step(1, 4'b1000, "sat_d");
            step(1, 4'b0100, "sat_e"); step(1, 4'b0100, "sat_f");
        end
        check("t5.err_sat_const", int'(err_count), 255);

        // Randomized run
        src = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                step(0, W'($urandom_range(0, 15)), "rnd_idle");
            end else if (r < 85) begin
                src = (src + 1) % W;
                val = W'(1 << src);
                step(1, val, "rnd_good");
            end else if (r < 92) begin
                src = $urandom_range(0, W - 1);
                val = W'(1 << src);
                step(1, val, "rnd_jump");
            end else begin
                step(1, W'($urandom_range(0, 15)), "rnd_any");
            end
            if (i == 1500) begin
                @(posedge clk);
                #3;
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
